rx_fc_credit_manager: RTL and testbench

Receive-side flow-control credit manager for the PCIe Gen5 Transaction Layer: the counterpart of the TX FC gate in front of the TX arbiter. It tracks credits consumed by TLPs the DLL delivers into the RX buffers and credits freed when the RX consumers drain them. It returns freed credits to the DLL as InitFC/UpdateFC requests over a valid/ready handshake. It also flags receiver-overflow errors.

---
 rtl/rx_fc_credit_manager_pkg.sv | 39 +++
 rtl/rx_fc_credit_manager_if.sv | 35 +++
 rtl/rx_fc_credit_manager_class_tracker.sv | 57 +++++
 rtl/rx_fc_credit_manager.sv | 151 +++++++++++++++
 tb/tb_rx_fc_credit_manager.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/rx_fc_credit_manager_pkg.sv
// rtl/rx_fc_credit_manager_pkg.sv - shared FC widths, class and FSM types, round-robin helper
package rx_fc_credit_manager_pkg;

  localparam int FC_HDR_WIDTH  = 8;
  localparam int FC_DATA_WIDTH = 12;
  localparam int FC_NUM_TYPES  = 3;

  typedef enum logic [1:0] {
    FC_P   = 2'd0,
    FC_NP  = 2'd1,
    FC_CPL = 2'd2
  } FC_type_t;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_SEND = 2'd2
  } fc_state_t;

  function automatic FC_type_t fc_next(input FC_type_t t);
    case (t)
      FC_P:    return FC_NP;
      FC_NP:   return FC_CPL;
      default: return FC_P;
    endcase
  endfunction

  // Search order starts just after the last-sent class; the last-sent class is tried last.
  function automatic FC_type_t fc_rr_pick(input logic [2:0] pend, input FC_type_t last);
    FC_type_t c1;
    FC_type_t c2;
    c1 = fc_next(last);
    c2 = fc_next(c1);
    if (pend[c1]) return c1;
    if (pend[c2]) return c2;
    return last;
  endfunction

endpackage

// File: rtl/rx_fc_credit_manager_if.sv
// rtl/rx_fc_credit_manager_if.sv - RX TLP, release, FC update and overflow signal bundle
interface rx_fc_credit_manager_if;
  import rx_fc_credit_manager_pkg::*;

  logic                     rx_tlp_valid;
  FC_type_t                 rx_tlp_type;
  logic [FC_DATA_WIDTH-1:0] rx_tlp_data_cr;
  logic                     rel_valid;
  FC_type_t                 rel_type;
  logic [FC_DATA_WIDTH-1:0] rel_data_cr;
  logic                     fc_upd_valid;
  logic                     fc_upd_ready;
  FC_type_t                 fc_upd_type;
  logic [FC_HDR_WIDTH-1:0]  fc_upd_hdr;
  logic [FC_DATA_WIDTH-1:0] fc_upd_data;
  logic                     fc_overflow_err;
  FC_type_t                 fc_overflow_type;

  modport master (
    input  rx_tlp_valid, rx_tlp_type, rx_tlp_data_cr,
    input  rel_valid, rel_type, rel_data_cr,
    input  fc_upd_ready,
    output fc_upd_valid, fc_upd_type, fc_upd_hdr, fc_upd_data,
    output fc_overflow_err, fc_overflow_type
  );

  modport slave (
    output rx_tlp_valid, rx_tlp_type, rx_tlp_data_cr,
    output rel_valid, rel_type, rel_data_cr,
    output fc_upd_ready,
    input  fc_upd_valid, fc_upd_type, fc_upd_hdr, fc_upd_data,
    input  fc_overflow_err, fc_overflow_type
  );

endinterface

// File: rtl/rx_fc_credit_manager_class_tracker.sv
// rtl/rx_fc_credit_manager_class_tracker.sv - alloc/rcvd counters and overflow detect for one FC class
module rx_fc_class_tracker
  import rx_fc_credit_manager_pkg::*;
#(
  parameter int HDR_INIT  = 0,
  parameter int DATA_INIT = 0
) (
  input  logic                     clk,
  input  logic                     arst,
  input  logic                     rx_hit,
  input  logic [FC_DATA_WIDTH-1:0] rx_data_cr,
  input  logic                     rel_hit,
  input  logic [FC_DATA_WIDTH-1:0] rel_data_cr,
  output logic [FC_HDR_WIDTH-1:0]  alloc_hdr,
  output logic [FC_DATA_WIDTH-1:0] alloc_data,
  output logic                     ovf,
  output logic                     pend_set
);

  localparam bit HDR_INF  = (HDR_INIT == 0);
  localparam bit DATA_INF = (DATA_INIT == 0);

  logic [FC_HDR_WIDTH-1:0]  alloc_hdr_q, rcvd_hdr_q, avail_hdr;
  logic [FC_DATA_WIDTH-1:0] alloc_data_q, rcvd_data_q, avail_data;
  logic                     hdr_ovf, data_ovf;

  // Availability is the modular distance, so wrapped counters still compare correctly.
  assign avail_hdr  = alloc_hdr_q - rcvd_hdr_q;
  assign avail_data = alloc_data_q - rcvd_data_q;

  assign hdr_ovf  = !HDR_INF  && rx_hit && (avail_hdr == '0);
  assign data_ovf = !DATA_INF && rx_hit && (rx_data_cr > avail_data);
  assign ovf      = hdr_ovf | data_ovf;

  assign pend_set   = rel_hit && !(HDR_INF && DATA_INF);
  assign alloc_hdr  = alloc_hdr_q;
  assign alloc_data = alloc_data_q;

  always_ff @(posedge clk) begin
    if (arst) begin
      alloc_hdr_q  <= HDR_INF  ? '0 : FC_HDR_WIDTH'(HDR_INIT);
      rcvd_hdr_q   <= '0;
      alloc_data_q <= DATA_INF ? '0 : FC_DATA_WIDTH'(DATA_INIT);
      rcvd_data_q  <= '0;
    end else begin
      if (!HDR_INF) begin
        if (rx_hit)  rcvd_hdr_q  <= rcvd_hdr_q + 1'b1;
        if (rel_hit) alloc_hdr_q <= alloc_hdr_q + 1'b1;
      end
      if (!DATA_INF) begin
        if (rx_hit)  rcvd_data_q  <= rcvd_data_q + rx_data_cr;
        if (rel_hit) alloc_data_q <= alloc_data_q + rel_data_cr;
      end
    end
  end

endmodule

// File: rtl/rx_fc_credit_manager.sv
// rtl/rx_fc_credit_manager.sv - RX FC credit manager: update FSM, round-robin, refresh timer, outputs
module rx_fc_credit_manager
  import rx_fc_credit_manager_pkg::*;
#(
  parameter int P_HDR_INIT    = 32,
  parameter int P_DATA_INIT   = 256,
  parameter int NP_HDR_INIT   = 32,
  parameter int NP_DATA_INIT  = 32,
  parameter int CPL_HDR_INIT  = 0,
  parameter int CPL_DATA_INIT = 0,
  parameter int UPDATE_PERIOD = 4096
) (
  input  logic                  clk,
  input  logic                  arst,
  rx_fc_credit_manager_if.master bus
);

  localparam int TIMER_W = $clog2(UPDATE_PERIOD + 1);

  logic [FC_HDR_WIDTH-1:0]  alloc_hdr  [FC_NUM_TYPES];
  logic [FC_DATA_WIDTH-1:0] alloc_data [FC_NUM_TYPES];
  logic [2:0]               rx_hit, rel_hit, ovf, pend_set;

  fc_state_t                state_q, state_d;
  logic                     in_init_q;
  FC_type_t                 init_cls_q, last_q;
  logic [2:0]               pending_q, pending_d, clr;
  logic [TIMER_W-1:0]       timer_q;
  logic                     expire, hs, load;
  FC_type_t                 load_cls;

  logic                     upd_valid_q;
  FC_type_t                 upd_type_q;
  logic [FC_HDR_WIDTH-1:0]  upd_hdr_q;
  logic [FC_DATA_WIDTH-1:0] upd_data_q;
  logic                     ovf_err_q;
  FC_type_t                 ovf_type_q;

  assign rx_hit  = {bus.rx_tlp_valid && (bus.rx_tlp_type == FC_CPL),
                    bus.rx_tlp_valid && (bus.rx_tlp_type == FC_NP),
                    bus.rx_tlp_valid && (bus.rx_tlp_type == FC_P)};
  assign rel_hit = {bus.rel_valid && (bus.rel_type == FC_CPL),
                    bus.rel_valid && (bus.rel_type == FC_NP),
                    bus.rel_valid && (bus.rel_type == FC_P)};

  rx_fc_class_tracker #(.HDR_INIT(P_HDR_INIT), .DATA_INIT(P_DATA_INIT)) u_p (
    .clk(clk), .arst(arst),
    .rx_hit(rx_hit[0]), .rx_data_cr(bus.rx_tlp_data_cr),
    .rel_hit(rel_hit[0]), .rel_data_cr(bus.rel_data_cr),
    .alloc_hdr(alloc_hdr[0]), .alloc_data(alloc_data[0]),
    .ovf(ovf[0]), .pend_set(pend_set[0])
  );

  rx_fc_class_tracker #(.HDR_INIT(NP_HDR_INIT), .DATA_INIT(NP_DATA_INIT)) u_np (
    .clk(clk), .arst(arst),
    .rx_hit(rx_hit[1]), .rx_data_cr(bus.rx_tlp_data_cr),
    .rel_hit(rel_hit[1]), .rel_data_cr(bus.rel_data_cr),
    .alloc_hdr(alloc_hdr[1]), .alloc_data(alloc_data[1]),
    .ovf(ovf[1]), .pend_set(pend_set[1])
  );

  rx_fc_class_tracker #(.HDR_INIT(CPL_HDR_INIT), .DATA_INIT(CPL_DATA_INIT)) u_cpl (
    .clk(clk), .arst(arst),
    .rx_hit(rx_hit[2]), .rx_data_cr(bus.rx_tlp_data_cr),
    .rel_hit(rel_hit[2]), .rel_data_cr(bus.rel_data_cr),
    .alloc_hdr(alloc_hdr[2]), .alloc_data(alloc_data[2]),
    .ovf(ovf[2]), .pend_set(pend_set[2])
  );

  assign hs     = upd_valid_q && bus.fc_upd_ready;
  assign expire = (timer_q == TIMER_W'(UPDATE_PERIOD - 1));

  always_ff @(posedge clk) begin
    if (arst) state_q <= ST_INIT;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    load_cls = FC_P;
    case (state_q)
      ST_INIT: begin
        load     = 1'b1;
        load_cls = init_cls_q;
        state_d  = ST_SEND;
      end
      ST_IDLE: begin
        if (|pending_q) begin
          load     = 1'b1;
          load_cls = fc_rr_pick(pending_q, last_q);
          state_d  = ST_SEND;
        end
      end
      ST_SEND: begin
        if (hs) state_d = (in_init_q && (upd_type_q != FC_CPL)) ? ST_INIT : ST_IDLE;
      end
      default: state_d = ST_INIT;
    endcase
  end

  // A release landing on the capture cycle must survive the clear: set wins over clear.
  always_comb begin
    clr       = load ? (3'b001 << load_cls) : 3'b000;
    pending_d = (pending_q & ~clr) | pend_set | {3{expire}};
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      in_init_q   <= 1'b1;
      init_cls_q  <= FC_P;
      last_q      <= FC_CPL;
      pending_q   <= 3'b000;
      timer_q     <= '0;
      upd_valid_q <= 1'b0;
      upd_type_q  <= FC_P;
      upd_hdr_q   <= '0;
      upd_data_q  <= '0;
      ovf_err_q   <= 1'b0;
      ovf_type_q  <= FC_P;
    end else begin
      pending_q <= pending_d;
      timer_q   <= (hs || expire) ? '0 : timer_q + 1'b1;
      if (hs) begin
        last_q <= upd_type_q;
        if (in_init_q) begin
          init_cls_q <= fc_next(init_cls_q);
          in_init_q  <= (upd_type_q != FC_CPL);
        end
      end
      if (load) begin
        upd_valid_q <= 1'b1;
        upd_type_q  <= load_cls;
        upd_hdr_q   <= alloc_hdr[load_cls];
        upd_data_q  <= alloc_data[load_cls];
      end else if (hs) begin
        upd_valid_q <= 1'b0;
      end
      ovf_err_q  <= |ovf;
      ovf_type_q <= ovf[2] ? FC_CPL : (ovf[1] ? FC_NP : FC_P);
    end
  end

  assign bus.fc_upd_valid     = upd_valid_q;
  assign bus.fc_upd_type      = upd_type_q;
  assign bus.fc_upd_hdr       = upd_hdr_q;
  assign bus.fc_upd_data      = upd_data_q;
  assign bus.fc_overflow_err  = ovf_err_q;
  assign bus.fc_overflow_type = ovf_type_q;

endmodule

// File: tb/tb_rx_fc_credit_manager.sv
// tb/tb_rx_fc_credit_manager.sv - directed table and sequence bench for rx_fc_credit_manager
module tb_rx_fc_credit_manager;
  import rx_fc_credit_manager_pkg::*;

  logic clk;
  logic arst;
  int   total;
  int   passed;

  rx_fc_credit_manager_if bus ();

  rx_fc_credit_manager dut (
    .clk (clk),
    .arst(arst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic     rdy;
    logic     rxv;
    FC_type_t rxt;
    int       rxcr;
    logic     relv;
    FC_type_t relt;
    int       relcr;
    logic     ev;
    logic     pay;
    FC_type_t et;
    int       eh;
    int       ed;
    logic     eo;
    FC_type_t eot;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rdy, input logic rxv, input FC_type_t rxt, input int rxcr,
                     input logic relv, input FC_type_t relt, input int relcr,
                     input logic ev, input logic pay, input FC_type_t et, input int eh, input int ed,
                     input logic eo, input FC_type_t eot);
    vec_t v;
    v.rdy = rdy; v.rxv = rxv; v.rxt = rxt; v.rxcr = rxcr;
    v.relv = relv; v.relt = relt; v.relcr = relcr;
    v.ev = ev; v.pay = pay; v.et = et; v.eh = eh; v.ed = ed; v.eo = eo; v.eot = eot;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s [%0d]: got %0d expected %0d", name, idx, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.rx_tlp_valid   = 1'b0;
    bus.rx_tlp_type    = FC_P;
    bus.rx_tlp_data_cr = '0;
    bus.rel_valid      = 1'b0;
    bus.rel_type       = FC_P;
    bus.rel_data_cr    = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    bus.fc_upd_ready = 1'b1;
    arst = 1'b1;
    step();
    step();
    arst = 1'b0;
  endtask

  task automatic run_init();
    bus.fc_upd_ready = 1'b1;
    repeat (6) step();
  endtask

  initial begin
    total  = 0;
    passed = 0;
    arst   = 1'b1;
    idle_inputs();
    bus.fc_upd_ready = 1'b1;

    // One row per cycle after reset: expected outputs for that cycle, then inputs driven in it.
    add(1'b1, 1'b0, FC_P,   0,    1'b0, FC_P,   0,  1'b0, 1'b1, FC_P,   0,  0,   1'b0, FC_P);
    add(1'b1, 1'b0, FC_P,   0,    1'b0, FC_P,   0,  1'b1, 1'b1, FC_P,   32, 256, 1'b0, FC_P);
    add(1'b1, 1'b0, FC_P,   0,    1'b0, FC_P,   0,  1'b0, 1'b0, FC_P,   0,  0,   1'b0, FC_P);
    add(1'b1, 1'b0, FC_P,   0,    1'b0, FC_P,   0,  1'b1, 1'b1, FC_NP,  32, 32,  1'b0, FC_P);
    add(1'b1, 1'b0, FC_P,   0,    1'b0, FC_P,   0,  1'b0, 1'b0, FC_P,   0,  0,   1'b0, FC_P);
    add(1'b1, 1'b0, FC_P,   0,    1'b0, FC_P,   0,  1'b1, 1'b1, FC_CPL, 0,  0,   1'b0, FC_P);
    add(1'b1, 1'b1, FC_P,   16,   1'b0, FC_P,   0,  1'b0, 1'b0, FC_P,   0,  0,   1'b0, FC_P);
    add(1'b1, 1'b0, FC_P,   0,    1'b1, FC_P,   16, 1'b0, 1'b0, FC_P,   0,  0,   1'b0, FC_P);
    add(1'b1, 1'b0, FC_P,   0,    1'b0, FC_P,   0,  1'b0, 1'b0, FC_P,   0,  0,   1'b0, FC_P);
    add(1'b0, 1'b0, FC_P,   0,    1'b1, FC_P,   3,  1'b1, 1'b1, FC_P,   33, 272, 1'b0, FC_P);
    add(1'b0, 1'b0, FC_P,   0,    1'b1, FC_NP,  5,  1'b1, 1'b1, FC_P,   33, 272, 1'b0, FC_P);
    add(1'b1, 1'b0, FC_P,   0,    1'b0, FC_P,   0,  1'b1, 1'b1, FC_P,   33, 272, 1'b0, FC_P);
    add(1'b1, 1'b0, FC_P,   0,    1'b0, FC_P,   0,  1'b0, 1'b0, FC_P,   0,  0,   1'b0, FC_P);
    add(1'b1, 1'b0, FC_P,   0,    1'b0, FC_P,   0,  1'b1, 1'b1, FC_NP,  33, 37,  1'b0, FC_P);
    add(1'b1, 1'b0, FC_P,   0,    1'b0, FC_P,   0,  1'b0, 1'b0, FC_P,   0,  0,   1'b0, FC_P);
    add(1'b1, 1'b0, FC_P,   0,    1'b0, FC_P,   0,  1'b1, 1'b1, FC_P,   34, 275, 1'b0, FC_P);
    add(1'b1, 1'b1, FC_NP,  40,   1'b0, FC_P,   0,  1'b0, 1'b0, FC_P,   0,  0,   1'b0, FC_P);
    add(1'b1, 1'b1, FC_P,   259,  1'b0, FC_P,   0,  1'b0, 1'b0, FC_P,   0,  0,   1'b1, FC_NP);
    add(1'b1, 1'b1, FC_P,   1,    1'b0, FC_P,   0,  1'b0, 1'b0, FC_P,   0,  0,   1'b0, FC_P);
    add(1'b1, 1'b1, FC_CPL, 4095, 1'b1, FC_CPL, 9,  1'b0, 1'b0, FC_P,   0,  0,   1'b1, FC_P);
    add(1'b1, 1'b0, FC_P,   0,    1'b0, FC_P,   0,  1'b0, 1'b0, FC_P,   0,  0,   1'b0, FC_P);
    add(1'b1, 1'b0, FC_P,   0,    1'b0, FC_P,   0,  1'b0, 1'b0, FC_P,   0,  0,   1'b0, FC_P);

    do_reset();
    for (int i = 0; i < vecs.size(); i++) begin
      check("valid", i, int'(bus.fc_upd_valid), int'(vecs[i].ev));
      if (vecs[i].pay) begin
        check("type", i, int'(bus.fc_upd_type), int'(vecs[i].et));
        check("hdr", i, int'(bus.fc_upd_hdr), vecs[i].eh);
        check("data", i, int'(bus.fc_upd_data), vecs[i].ed);
      end
      check("ovf", i, int'(bus.fc_overflow_err), int'(vecs[i].eo));
      if (vecs[i].eo) check("ovf_type", i, int'(bus.fc_overflow_type), int'(vecs[i].eot));
      bus.fc_upd_ready   = vecs[i].rdy;
      bus.rx_tlp_valid   = vecs[i].rxv;
      bus.rx_tlp_type    = vecs[i].rxt;
      bus.rx_tlp_data_cr = FC_DATA_WIDTH'(vecs[i].rxcr);
      bus.rel_valid      = vecs[i].relv;
      bus.rel_type       = vecs[i].relt;
      bus.rel_data_cr    = FC_DATA_WIDTH'(vecs[i].relcr);
      step();
    end
    idle_inputs();

    // 33 P headers against 32 advertised: exactly one pulse, seen right after the 33rd.
    begin
      int pulses;
      int pulse_at;
      int pulse_type;
      pulses = 0;
      pulse_at = -1;
      pulse_type = -1;
      do_reset();
      run_init();
      bus.rx_tlp_valid   = 1'b1;
      bus.rx_tlp_type    = FC_P;
      bus.rx_tlp_data_cr = '0;
      for (int i = 1; i <= 34; i++) begin
        step();
        if (bus.fc_overflow_err) begin
          pulses++;
          pulse_at = i;
          pulse_type = int'(bus.fc_overflow_type);
        end
        if (i == 33) bus.rx_tlp_valid = 1'b0;
      end
      check("hdr_ovf_pulses", 0, pulses, 1);
      check("hdr_ovf_at", 0, pulse_at, 33);
      check("hdr_ovf_type", 0, pulse_type, int'(FC_P));
    end

    // Payload held under backpressure, then reset mid-SEND restarts the INIT sequence.
    begin
      int seen;
      int changes;
      int h0;
      int d0;
      int t0;
      seen = 0;
      changes = 0;
      do_reset();
      run_init();
      bus.fc_upd_ready = 1'b0;
      bus.rel_valid    = 1'b1;
      bus.rel_type     = FC_P;
      bus.rel_data_cr  = 12'd7;
      step();
      bus.rel_valid = 1'b0;
      for (int k = 0; k < 5 && seen == 0; k++) begin
        if (bus.fc_upd_valid) seen = 1;
        else step();
      end
      check("bp_valid_seen", 0, seen, 1);
      t0 = int'(bus.fc_upd_type);
      h0 = int'(bus.fc_upd_hdr);
      d0 = int'(bus.fc_upd_data);
      check("bp_type", 0, t0, int'(FC_P));
      check("bp_hdr", 0, h0, 33);
      check("bp_data", 0, d0, 263);
      for (int k = 0; k < 10; k++) begin
        step();
        if (!bus.fc_upd_valid || int'(bus.fc_upd_type) != t0 ||
            int'(bus.fc_upd_hdr) != h0 || int'(bus.fc_upd_data) != d0) changes++;
      end
      check("bp_stable", 0, changes, 0);
      arst = 1'b1;
      step();
      check("rst_mid_send_valid", 0, int'(bus.fc_upd_valid), 0);
      arst = 1'b0;
      bus.fc_upd_ready = 1'b1;
      step();
      check("restart_valid", 0, int'(bus.fc_upd_valid), 1);
      check("restart_type", 0, int'(bus.fc_upd_type), int'(FC_P));
      check("restart_hdr", 0, int'(bus.fc_upd_hdr), 32);
      check("restart_data", 0, int'(bus.fc_upd_data), 256);
    end

    // Idle link: the refresh timer re-advertises all three classes with unchanged values.
    begin
      int n;
      int first_at;
      int got_t[3];
      int got_h[3];
      int got_d[3];
      n = 0;
      first_at = -1;
      do_reset();
      run_init();
      for (int k = 0; k < 4300 && n < 3; k++) begin
        if (bus.fc_upd_valid) begin
          if (n == 0) first_at = k;
          got_t[n] = int'(bus.fc_upd_type);
          got_h[n] = int'(bus.fc_upd_hdr);
          got_d[n] = int'(bus.fc_upd_data);
          n++;
        end
        step();
      end
      check("refresh_count", 0, n, 3);
      check("refresh_not_early", 0, int'(first_at >= 4085 && first_at <= 4105), 1);
      if (n == 3) begin
        check("refresh_type", 0, got_t[0], int'(FC_P));
        check("refresh_hdr", 0, got_h[0], 32);
        check("refresh_data", 0, got_d[0], 256);
        check("refresh_type", 1, got_t[1], int'(FC_NP));
        check("refresh_hdr", 1, got_h[1], 32);
        check("refresh_data", 1, got_d[1], 32);
        check("refresh_type", 2, got_t[2], int'(FC_CPL));
        check("refresh_hdr", 2, got_h[2], 0);
        check("refresh_data", 2, got_d[2], 0);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
